// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: stall bus encoding, bus widths,
// ram_read load/store codes and the EX->MEM field layout.
package mem_stage_pkg;

  localparam int STALL_W      = 6;
  localparam int STALL_MEM    = 3;
  localparam int STALL_WB     = 4;
  localparam int EX_TO_MEM_WD = 80;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;
  localparam int HL_WD        = 66;

  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [3:0] LD_NONE = 4'b0000;
  localparam logic [3:0] LD_LB   = 4'b0001;
  localparam logic [3:0] LD_LBU  = 4'b0010;
  localparam logic [3:0] LD_LH   = 4'b0011;
  localparam logic [3:0] LD_LHU  = 4'b0100;
  localparam logic [3:0] ST_SB   = 4'b0101;
  localparam logic [3:0] ST_SH   = 4'b0111;
  localparam logic [3:0] LD_LW   = 4'b1111;

  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [3:0]  ram_read;
  } ex_to_mem_t;

  typedef enum logic [1:0] {
    LS_IDLE,
    LS_WAIT,
    LS_HOLD
  } ld_state_e;

  function automatic logic is_load(input logic ram_en, input logic sel_rf_res,
                                   input logic [3:0] code);
    return ram_en && sel_rf_res &&
           (code inside {LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW});
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/halfword/word out of a little-endian read word and
// sign- or zero-extends it to 32 bits.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [3:0]  ram_read,
  output logic [31:0] ld_value
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0] bs;
    bs = b;
    return sgn ? {{24{bs[7]}}, bs} : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0] hs;
    hs = h;
    return sgn ? {{16{hs[15]}}, hs} : {16'd0, h};
  endfunction

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Misaligned halfwords only look at addr[1]; words ignore addr entirely.
  assign sel_byte = rdata[{addr, 3'b000} +: 8];
  assign sel_half = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_value = 32'd0;
    unique case (ram_read)
      LD_LB:   ld_value = ext_byte(sel_byte, 1'b1);
      LD_LBU:  ld_value = ext_byte(sel_byte, 1'b0);
      LD_LH:   ld_value = ext_half(sel_half, 1'b1);
      LD_LHU:  ld_value = ext_half(sel_half, 1'b0);
      LD_LW:   ld_value = rdata;
      default: ld_value = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: stall-aware input register, fixed-latency load data
// collection with hold buffer, forwarding to ID and result bus to WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [HL_WD-1:0]        hl_ex_to_mem,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [HL_WD-1:0]        hl_mem_to_wb,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  output logic [HL_WD-1:0]        mem_to_id_hl,
  output logic                    stallreq_for_mem
);

  localparam logic [2:0] LAT   = 3'(RD_LAT);
  localparam logic       MULTI = (RD_LAT > 1);

  logic [EX_TO_MEM_WD-1:0] ex_bus_p0;
  logic [HL_WD-1:0]        hl_p0;
  logic [31:0]             buf_p0;
  logic [2:0]              cnt_p0, cnt_nxt;
  ld_state_e               state_p0, state_nxt;
  ex_to_mem_t              in_ins, ins_p0;
  logic                    adv, bubble, in_load, ld_p0, data_here, buf_we;
  logic [31:0]             load_word, ld_value, rf_wdata;

  assign adv     = (stall[STALL_MEM] == NoStop);
  assign bubble  = (stall[STALL_MEM] == Stop) && (stall[STALL_WB] == NoStop);
  assign in_ins  = ex_to_mem_t'(ex_to_mem_bus);
  assign ins_p0  = ex_to_mem_t'(ex_bus_p0);
  assign in_load = is_load(in_ins.ram_en, in_ins.sel_rf_res, in_ins.ram_read);
  assign ld_p0   = is_load(ins_p0.ram_en, ins_p0.sel_rf_res, ins_p0.ram_read);

  // Stage p0: instruction and HI/LO register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_bus_p0 <= '0;
      hl_p0     <= '0;
    end else if (bubble) begin
      ex_bus_p0 <= '0;
      hl_p0     <= '0;
    end else if (adv) begin
      ex_bus_p0 <= ex_to_mem_bus;
      hl_p0     <= hl_ex_to_mem;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_p0 <= LS_IDLE;
      cnt_p0   <= '0;
      buf_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      if (buf_we) buf_p0 <= data_sram_rdata;
    end
  end

  // Read data is valid exactly once: RD_LAT=1 on entry, else when cnt hits RD_LAT.
  assign data_here = ((state_p0 == LS_IDLE) && ld_p0 && !MULTI) ||
                     ((state_p0 == LS_WAIT) && (cnt_p0 == LAT));

  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    buf_we    = 1'b0;
    if (bubble) begin
      state_nxt = LS_IDLE;
      cnt_nxt   = '0;
    end else if (adv) begin
      state_nxt = (in_load && MULTI) ? LS_WAIT : LS_IDLE;
      cnt_nxt   = (in_load && MULTI) ? 3'd1 : 3'd0;
    end else if (data_here) begin
      state_nxt = LS_HOLD;
      cnt_nxt   = '0;
      buf_we    = 1'b1;
    end else if (state_p0 == LS_WAIT) begin
      cnt_nxt = cnt_p0 + 3'd1;
    end
  end

  assign stallreq_for_mem = (state_p0 == LS_WAIT) && (cnt_p0 < LAT);
  assign load_word        = (state_p0 == LS_HOLD) ? buf_p0 : data_sram_rdata;

  mem_stage_load_align u_load_align (
    .rdata    (load_word),
    .addr     (ins_p0.ex_result[1:0]),
    .ram_read (ins_p0.ram_read),
    .ld_value (ld_value)
  );

  assign rf_wdata      = ld_p0 ? ld_value : ins_p0.ex_result;
  assign mem_to_wb_bus = {ins_p0.pc, ins_p0.rf_we, ins_p0.rf_waddr, rf_wdata};
  assign mem_to_id_bus = {ins_p0.rf_we, ins_p0.rf_waddr, rf_wdata};
  assign hl_mem_to_wb  = hl_p0;
  assign mem_to_id_hl  = hl_p0;

  logic unused_ok;
  assign unused_ok = ^{stall[5], stall[2:0], ins_p0.ram_wen, in_ins};

endmodule
